pos_acc_shifted: RTL
====================

Name: pos_acc_shifted

Overview:
- Sequential, chunk-serial accumulator: acc <= acc ± (b << shift), modulo 2^N_BITS_ACC.
- Shift amount is chosen per transaction, and each transaction can add or subtract.
- Used in Karatsuba recombination to fold partial products (z0, z1, z2) into one wide result without a full-width adder.
- Processes CHUNK bits per cycle with a registered carry, and uses a valid/ready handshake.

Parameters:
- N_BITS_ACC, 32, accumulator width; must be a multiple of CHUNK.
- N_BITS_IN, 16, width of operand b.
- CHUNK, 8, bits added per cycle; NCHUNK = N_BITS_ACC/CHUNK.
- SHIFT_BITS, 5, width of the shift port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  zero acc and ovf; honoured only while in_ready=1.
- in_valid  in  1  operand valid.
- in_ready  out  1  block idle, can accept.
- b  in  N_BITS_IN  unsigned operand.
- shift  in  SHIFT_BITS  left shift applied to b.
- sub  in  1  0: acc+=operand; 1: acc-=operand.
- acc  out  N_BITS_ACC  committed accumulator value.
- ovf  out  1  sticky overflow/underflow/truncation flag.
- done  out  1  one-cycle pulse when a result is committed.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - acc=0, ovf=0, done=0, in_ready=1, state=IDLE.
  - rst overrides every other input and aborts any RUN in progress; no done is issued for the aborted transaction.
- States: IDLE (in_ready=1) and RUN (in_ready=0).
- IDLE behaviour:
  - clr=1 and in_valid=0: acc<=0, ovf<=0 at the edge.
  - clr=1 and in_valid=1: the transaction is accepted with base value 0 and ovf cleared. This acts as "load ±(b<<shift)".
- Acceptance (in_valid && in_ready at edge E0):
  - Latch op = (b << shift) truncated to N_BITS_ACC, and latch sub.
  - Copy acc (or 0 if clr) into the work register.
  - Carry <= sub.
  - Go to RUN with chunk index k=0.
  - If any set bit of b is shifted at or beyond bit N_BITS_ACC, set trunc_pending. This includes shift >= N_BITS_ACC with b != 0.
- RUN, edge Ek+1 for k = 0..NCHUNK-1:
  - work[k] <= work[k] + (sub ? ~op[k] : op[k]) + carry, where [k] denotes bits [k*CHUNK +: CHUNK].
  - carry <= carry-out of that chunk add.
  - k <= k+1.
- Commit at edge E_NCHUNK (last chunk):
  - acc <= work, including the last chunk result.
  - ovf <= ovf | trunc_pending | (sub ? ~carry_out : carry_out).
  - done=1 for exactly the following cycle.
  - Return to IDLE; in_ready=1 in the same cycle as done.
- Timing and stability:
  - in_ready is low for exactly NCHUNK cycles per transaction.
  - Back-to-back throughput is one transaction per NCHUNK+1 cycles.
  - acc is stable, holding the old value, throughout RUN. It changes only on commit, clr, or rst.
- Ignored inputs during RUN: in_valid, b, shift, sub and clr have no effect.
- shift = 0 is legal; op is then b zero-extended.
- All arithmetic wraps modulo 2^N_BITS_ACC; ovf records the wrap.
- ovf is cleared only by rst or clr.

Test Plan (defaults: N_BITS_ACC=32, N_BITS_IN=16, CHUNK=8):
- rst for 2 cycles -> acc=0x00000000, ovf=0, done=0, in_ready=1.
- clr=1, in_valid=1, b=0x00FF, shift=0, sub=0 -> in_ready low 4 cycles, done pulse, acc=0x000000FF; then b=0x0001 -> acc=0x00000100 (carry crosses chunk 0→1), ovf=0.
- From acc=0: b=0xABCD, shift=8, add -> acc=0x00ABCD00 exactly 4 edges after acceptance. in_valid held high during RUN with b=0x1111 has no effect.
- From acc=0: b=0x0001, shift=0, sub=1 -> acc=0xFFFFFFFF, ovf=1. Then clr alone -> acc=0, ovf=0.
- From acc=0: b=0xFFFF, shift=20, add -> acc=0xFFF00000, ovf=1 (truncation). From acc=0: b=0x0001, shift=31 -> acc=0x80000000, ovf=0.
- Accept a transaction, assert rst at the 2nd RUN edge -> acc=0, in_ready=1 the next cycle, no done pulse.

Source files
------------

// File: rtl/pos_acc_shifted.sv
// Chunk-serial shifted accumulator: acc <= acc +/- (b << shift) mod 2^N_BITS_ACC.
// One CHUNK-wide add per cycle with a registered carry between chunks.
module pos_acc_shifted #(
  parameter int N_BITS_ACC = 32,
  parameter int N_BITS_IN  = 16,
  parameter int CHUNK      = 8,
  parameter int SHIFT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS_IN-1:0]  b,
  input  logic [SHIFT_BITS-1:0] shift,
  input  logic                  sub,
  output logic [N_BITS_ACC-1:0] acc,
  output logic                  ovf,
  output logic                  done
);

  localparam int NCHUNK = N_BITS_ACC / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int WW     = N_BITS_ACC + N_BITS_IN + (1 << SHIFT_BITS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic [N_BITS_ACC-1:0] acc_q;
  logic [N_BITS_ACC-1:0] work_q;
  logic [N_BITS_ACC-1:0] op_q;
  logic [N_BITS_ACC-1:0] work_d;
  logic                  ovf_q;
  logic                  done_q;
  logic                  sub_q;
  logic                  carry_q;
  logic                  trunc_q;
  logic [KW-1:0]         k_q;
  logic [WW-1:0]         wide;
  logic [CHUNK-1:0]      op_c;
  logic [CHUNK:0]        sum_c;
  logic                  last;

  // Wide shift so bits pushed past the accumulator can be detected.
  always_comb begin
    wide   = WW'(b) << shift;
    op_c   = op_q[k_q*CHUNK +: CHUNK];
    if (sub_q) op_c = ~op_c;
    sum_c  = {1'b0, work_q[k_q*CHUNK +: CHUNK]}
           + {1'b0, op_c}
           + (CHUNK+1)'(carry_q);
    work_d = work_q;
    work_d[k_q*CHUNK +: CHUNK] = sum_c[CHUNK-1:0];
    last   = (k_q == KW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      work_q  <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      trunc_q <= 1'b0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= wide[N_BITS_ACC-1:0];
            trunc_q <= |wide[WW-1:N_BITS_ACC];
            sub_q   <= sub;
            carry_q <= sub;
            work_q  <= clr ? '0 : acc_q;
            k_q     <= '0;
            state_q <= RUN;
            if (clr) ovf_q <= 1'b0;
          end else if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= sum_c[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last) begin
            // Subtract wraps when the final borrow is present.
            acc_q   <= work_d;
            ovf_q   <= ovf_q | trunc_q | (sub_q ^ sum_c[CHUNK]);
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule
